// File: rtl/candle_pkg.sv
// Shared types and constants for the candle PWM output stage.
//   state_t  : PWM controller state (IDLE, RUN, DRAIN)
//   PWM_BITS : width of the PWM counter and duty word
//   PWM_MAX  : last count of a PWM period
package candle_pkg;

   localparam int unsigned PWM_BITS = 8;
   localparam logic [PWM_BITS-1:0] PWM_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // True while the PWM counter is allowed to advance.
   function automatic logic is_running(input state_t s);
      return (s == RUN) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the PWM counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; the prescaler is held at 0 while low
//   step       : high in the cycle where the count reaches PRESCALE-1
module pwm_prescaler #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic step
);

   localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt;

   // With PRESCALE=1 LAST is 0, so step is simply en.
   assign step = en && (cnt == LAST);

   // Free-running 0..PRESCALE-1 counter, cleared while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en || step) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/candle_pwm.sv
// PWM LED driver for the candle flicker generator.
//   clk, rst_n  : clock, asynchronous active-low reset
//   run         : 1 = generate PWM, 0 = stop at the next period boundary
//   brightness  : requested duty, sampled only at period boundaries
//   pwm_out     : registered LED drive (active-low when INVERT=1)
//   period_tick : one-clock pulse on each counter wrap while active
//   active      : 1 while in RUN or DRAIN
//   duty_q      : duty currently applied (shadow register)
module candle_pwm
   import candle_pkg::*;
#(
   parameter int unsigned PRESCALE = 4,
   parameter bit          INVERT   = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic [PWM_BITS-1:0] brightness,
   output logic                pwm_out,
   output logic                period_tick,
   output logic                active,
   output logic [PWM_BITS-1:0] duty_q
);

   state_t              state, state_next;
   logic [PWM_BITS-1:0] cnt, cnt_next;
   logic [PWM_BITS-1:0] duty_next;
   logic                pwm_next;
   logic                tick_next;
   logic                active_next;
   logic                step;
   logic                wrap;

   // Prescaler runs only while the counter is live; IDLE holds it at 0.
   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (is_running(state)),
      .step  (step)
   );

   assign wrap = step && (cnt == PWM_MAX);

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         duty_q      <= '0;
         pwm_out     <= INVERT;
         period_tick <= 1'b0;
         active      <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         duty_q      <= duty_next;
         pwm_out     <= pwm_next;
         period_tick <= tick_next;
         active      <= active_next;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      duty_next   = duty_q;
      pwm_next    = INVERT;
      tick_next   = 1'b0;
      active_next = 1'b0;

      case (state)
         IDLE: begin
            cnt_next = '0;
            if (run) begin
               state_next = RUN;
               duty_next  = brightness;
            end
         end
         RUN: begin
            if (!run) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            // A returning run wins over a coincident wrap.
            if (run) begin
               state_next = RUN;
            end else if (wrap) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Counting, duty reload and output are identical in RUN and DRAIN.
      if (state != IDLE) begin
         pwm_next  = (cnt < duty_q) ^ INVERT;
         tick_next = wrap;
         if (step) begin
            cnt_next = cnt + PWM_BITS'(1);
         end
         if (wrap) begin
            duty_next = brightness;
         end
      end

      active_next = is_running(state_next);
   end

endmodule

// File: doc/candle_pwm.md
Name: candle_pwm

Overview:
Downstream stage of the candle flicker generator. It converts the 8-bit brightness word into a single-bit PWM LED drive. Duty is double-buffered and updated only at period boundaries, so the output never glitches mid-period. Each period wrap emits a one-cycle tick, which the top level uses as the flicker stage's enable so brightness steps once per PWM period.

Parameters:
PRESCALE, 4, clocks per PWM counter step; legal range 1..65535; 1 means a step every clock.
INVERT, 0, 1 drives pwm_out active-low; the inactive level is then 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
run  in  1  level; 1 = generate PWM, 0 = stop at the next period boundary
brightness  in  8  requested duty, from the flicker stage
pwm_out  out  1  LED drive, registered
period_tick  out  1  one-clk pulse on each counter wrap while active
active  out  1  1 in RUN or DRAIN
duty_q  out  8  duty currently applied (shadow register)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, prescaler=0, cnt=0, duty_q=0, period_tick=0, active=0, pwm_out=INVERT (inactive level).
- Prescaler:
  - Counts 0..PRESCALE-1 while in RUN or DRAIN; held at 0 in IDLE.
  - step=1 in each cycle where prescaler==PRESCALE-1; the prescaler returns to 0 on that cycle.
- PWM counter cnt (8 bit):
  - Increments on step.
  - wrap = step && cnt==255; cnt goes 255->0.
  - Period = 256*PRESCALE clocks.
- Duty load:
  - duty_q <= brightness on every wrap in RUN or DRAIN, and on the IDLE->RUN transition.
  - brightness is ignored at all other times.
- Output:
  - pwm_out <= (cnt < duty_q) ^ INVERT, computed from registered cnt/duty_q, so pwm_out lags cnt by 1 clk.
  - duty 0x00: never active. duty 0xFF: active for 255 of every 256 steps.
  - In IDLE: pwm_out <= INVERT.
- period_tick <= wrap && state!=IDLE; exactly one clk wide per period.
- active = (state==RUN || state==DRAIN), registered with the state.
- FSM:
  - IDLE -> RUN when run=1. On that edge: cnt=0, prescaler=0, duty_q<=brightness.
  - RUN -> DRAIN when run=0. Counting continues unchanged.
  - DRAIN -> IDLE on wrap when run=0. cnt is already 0.
  - DRAIN -> RUN when run=1, in any cycle including a wrap cycle. No counter disturbance.
- Simultaneous events:
  - Wrap and run falling in the same RUN cycle: tick emitted, duty loaded, next state DRAIN.
  - In DRAIN, run has priority over wrap.
- Run pulses shorter than one period: the block completes the current period, then returns to IDLE.
- Asynchronous reset mid-period: immediate return to the reset values; pwm_out goes inactive without waiting for clk.

Decomposition:
- Shared package candle_pkg:
  - state enum {IDLE, RUN, DRAIN}
  - PWM_BITS=8
  - PWM_MAX=8'hFF
- One sub-module, pwm_prescaler:
  - parameter PRESCALE; ports clk, rst_n, en, step.
  - Clears when en=0.
  - Counter width $clog2(PRESCALE) with a minimum of 1.

Test Plan:
1. PRESCALE=1, brightness=0x40, run=1 held -> pwm_out high exactly 64 of every 256 clks; period_tick every 256 clks; duty_q=0x40.
2. brightness 0x00, then 0xFF, changed mid-period -> duty_q and pwm_out change only after the next wrap; 0x00 gives constant 0; 0xFF gives 255 high / 1 low per period.
3. PRESCALE=4, run dropped at cnt=100 -> active stays 1 until wrap (156*4 clks later), one final period_tick, then IDLE with pwm_out=0.
4. run reasserted during DRAIN at cnt=200 -> state RUN, no wrap skipped, cnt continuity preserved, ticks remain periodic.
5. INVERT=1, brightness=0x80 -> pwm_out low 128 of 256 steps; idle/reset level 1.
6. rst_n asserted at cnt=77 with pwm_out active -> pwm_out, active and period_tick go to reset values before the next clk edge; after release the block starts in IDLE.
